// File: rtl/sdavinci_pkg.sv
// Shared definitions for the ifmap window read path.
//   SIZE, AW   : default lane count and per-lane address width
//   KMAX       : largest supported kernel size
//   state_t    : one-hot FSM encoding of ifm_window_rd
//   norm_ksize : maps a raw ksize input onto the supported 1..KMAX range
package sdavinci_pkg;

  localparam int SIZE = 8;
  localparam int AW   = 10;
  localparam int KMAX = 5;

  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    LOAD = 6'b000010,
    CAPT = 6'b000100,
    SCAN = 6'b001000,
    REQ  = 6'b010000,
    DONE = 6'b100000
  } state_t;

  // A kernel size of 0 is meaningless; treat it as a 1x1 kernel.
  function automatic logic [2:0] norm_ksize(input logic [2:0] k);
    if (k == 3'd0) return 3'd1;
    if (k > 3'(KMAX)) return 3'(KMAX);
    return k;
  endfunction

endpackage

// File: rtl/ifm_tap_counter.sv
// Kernel tap scanner: walks kr/kc over a ksize x ksize window, one tap per
// unstalled scan cycle, and accumulates the row offset (kr * tile_length)
// incrementally so no multiplier is needed.
//   clock, rst     : clock, async active-high reset
//   clear          : zero kr, kc and row_off (start of a group)
//   scan, stall    : a tap is taken when scan=1 and stall=0
//   ksize          : normalised kernel size, 1..KMAX
//   tile_length    : ifmap row pitch added to row_off per kernel row
//   kr, kc, row_off: current tap position
//   tap            : a tap is taken this cycle
//   first, last    : current tap is (0,0) / (ksize-1,ksize-1)
module ifm_tap_counter #(
  parameter int AW = 10
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          clear,
  input  logic          scan,
  input  logic          stall,
  input  logic [2:0]    ksize,
  input  logic [5:0]    tile_length,
  output logic [2:0]    kr,
  output logic [2:0]    kc,
  output logic [AW-1:0] row_off,
  output logic          tap,
  output logic          first,
  output logic          last
);

  logic kc_end;

  assign tap    = scan & ~stall;
  assign kc_end = (kc == ksize - 3'd1);
  assign first  = (kr == 3'd0) && (kc == 3'd0);
  assign last   = kc_end && (kr == ksize - 3'd1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      kr      <= '0;
      kc      <= '0;
      row_off <= '0;
    end else if (clear) begin
      kr      <= '0;
      kc      <= '0;
      row_off <= '0;
    end else if (tap) begin
      if (last) begin
        kr      <= '0;
        kc      <= '0;
        row_off <= '0;
      end else if (kc_end) begin
        kc      <= '0;
        kr      <= kr + 3'd1;
        row_off <= row_off + AW'(tile_length);
      end else begin
        kc <= kc + 3'd1;
      end
    end
  end

endmodule

// File: rtl/ifm_window_rd.sv
// Expands each group of SIZE window base addresses from ifm_addr_gen into
// ksize*ksize per-tap ifmap buffer read addresses, one tap per cycle for all
// lanes in parallel, requesting further groups until the generator flags the
// last one.
//   clock, rst      : clock, async active-high reset
//   base_address    : lane i base at [i*AW +: AW]
//   base_addr_valid : per-lane valid of the current group
//   addr_gen_done   : rising edge (in IDLE) starts a tile
//   ifmap_end       : current group is the tile's last
//   tile_length     : ifmap row pitch
//   ksize           : kernel size 1..5 (0 treated as 1)
//   rd_stall        : freeze the tap scan
//   tile_continue   : one-cycle request for the next group
//   rd_addr         : per-lane tap address, same packing as base_address
//   rd_valid        : per-lane tap valid
//   rd_first        : first tap of a group
//   rd_last         : last tap of a group
//   tile_done       : one-cycle pulse after the final tap of the tile
//   busy            : block is not idle
module ifm_window_rd #(
  parameter int SIZE = sdavinci_pkg::SIZE,
  parameter int AW   = sdavinci_pkg::AW
) (
  input  logic               clock,
  input  logic               rst,
  input  logic [SIZE*AW-1:0] base_address,
  input  logic [SIZE-1:0]    base_addr_valid,
  input  logic               addr_gen_done,
  input  logic               ifmap_end,
  input  logic [5:0]         tile_length,
  input  logic [2:0]         ksize,
  input  logic               rd_stall,
  output logic               tile_continue,
  output logic [SIZE*AW-1:0] rd_addr,
  output logic [SIZE-1:0]    rd_valid,
  output logic               rd_first,
  output logic               rd_last,
  output logic               tile_done,
  output logic               busy
);

  import sdavinci_pkg::*;

  state_t            state, state_nx;
  logic              adg_d;
  logic              first_grp;
  logic              end_l;
  logic [SIZE*AW-1:0] base_l;
  logic [SIZE-1:0]   valid_l;
  logic [5:0]        tl_l;
  logic [2:0]        ks_l;

  logic              tap, tap_first, tap_last;
  logic [2:0]        kr, kc;
  logic [AW-1:0]     row_off;
  logic [AW-1:0]     lane_sum [SIZE];

  ifm_tap_counter #(.AW(AW)) u_tap (
    .clock       (clock),
    .rst         (rst),
    .clear       (state == CAPT),
    .scan        (state == SCAN),
    .stall       (rd_stall),
    .ksize       (ks_l),
    .tile_length (tl_l),
    .kr          (kr),
    .kc          (kc),
    .row_off     (row_off),
    .tap         (tap),
    .first       (tap_first),
    .last        (tap_last)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: state_nx is given its hold value before the case so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (addr_gen_done && !adg_d) state_nx = LOAD;
      LOAD:    state_nx = CAPT;
      CAPT:    state_nx = SCAN;
      SCAN:    if (tap && tap_last) state_nx = end_l ? DONE : REQ;
      REQ:     state_nx = CAPT;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign tile_continue = (state == REQ);
  assign tile_done     = (state == DONE);
  assign busy          = (state != IDLE);

  // adg_d comes out of reset high so that an addr_gen_done already held high
  // across reset is not mistaken for a fresh rising edge.
  // NOTE: the group latches are few flops, not a RAM, so they take the
  // reset like any other register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      adg_d     <= 1'b1;
      first_grp <= 1'b0;
      end_l     <= 1'b0;
      base_l    <= '0;
      valid_l   <= '0;
      tl_l      <= '0;
      ks_l      <= 3'd1;
    end else begin
      adg_d <= addr_gen_done;
      if (state == LOAD) first_grp <= 1'b1;
      if (state == CAPT) begin
        first_grp <= 1'b0;
        base_l    <= base_address;
        valid_l   <= base_addr_valid;
        end_l     <= ifmap_end;
        if (first_grp) begin
          tl_l <= tile_length;
          ks_l <= norm_ksize(ksize);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      lane_sum[i] = base_l[i*AW +: AW] + row_off + AW'(kc);
    end
  end

  // Output register: one cycle behind the SCAN cycle that took the tap;
  // rd_addr holds between taps.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rd_addr  <= '0;
      rd_valid <= '0;
      rd_first <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= tap ? valid_l : '0;
      rd_first <= tap & tap_first;
      rd_last  <= tap & tap_last;
      if (tap) begin
        for (int i = 0; i < SIZE; i++) begin
          rd_addr[i*AW +: AW] <= lane_sum[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_ifm_window_rd.sv
// Self-checking bench for ifm_window_rd: emulates the base-address generator,
// predicts every tap as base + kr*tile_length + kc (mod 2^AW) and compares the
// DUT's output stream tap by tap.
module tb_ifm_window_rd;

  localparam int SIZE = 8;
  localparam int AW   = 10;

  logic               clock;
  logic               rst;
  logic [SIZE*AW-1:0] base_address;
  logic [SIZE-1:0]    base_addr_valid;
  logic               addr_gen_done;
  logic               ifmap_end;
  logic [5:0]         tile_length;
  logic [2:0]         ksize;
  logic               rd_stall;
  logic               tile_continue;
  logic [SIZE*AW-1:0] rd_addr;
  logic [SIZE-1:0]    rd_valid;
  logic               rd_first;
  logic               rd_last;
  logic               tile_done;
  logic               busy;

  ifm_window_rd #(.SIZE(SIZE), .AW(AW)) dut (
    .clock           (clock),
    .rst             (rst),
    .base_address    (base_address),
    .base_addr_valid (base_addr_valid),
    .addr_gen_done   (addr_gen_done),
    .ifmap_end       (ifmap_end),
    .tile_length     (tile_length),
    .ksize           (ksize),
    .rd_stall        (rd_stall),
    .tile_continue   (tile_continue),
    .rd_addr         (rd_addr),
    .rd_valid        (rd_valid),
    .rd_first        (rd_first),
    .rd_last         (rd_last),
    .tile_done       (tile_done),
    .busy            (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  // Generator contents for up to 4 groups per tile.
  logic [AW-1:0]   g_base  [4][SIZE];
  logic [SIZE-1:0] g_valid [4];

  // Results of the most recent run_tile.
  int r_cont, r_done, r_done_cyc, r_groups_seen;
  int r_first_cyc [4];
  int r_last_cyc  [4];

  task automatic drive_group(input int g, input int ngroups);
    for (int i = 0; i < SIZE; i++) base_address[i*AW +: AW] = g_base[g][i];
    base_addr_valid = g_valid[g];
    ifmap_end       = (g == ngroups - 1);
  endtask

  task automatic outputs_zero(input string name);
    n_total++;
    if (rd_addr !== '0 || rd_valid !== '0 || rd_first !== 1'b0 || rd_last !== 1'b0 ||
        tile_continue !== 1'b0 || tile_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s: addr=%h valid=%b first=%b last=%b cont=%b done=%b busy=%b, required all 0",
               name, rd_addr, rd_valid, rd_first, rd_last, tile_continue, tile_done, busy);
    else n_pass++;
  endtask

  // Runs one tile of ngroups groups and checks every tap against the model.
  // stall_at >= 0 holds rd_stall for stall_len cycles while tap stall_at of
  // the first group is pending; rand_stall stalls about one cycle in four.
  task automatic run_tile(input int ngroups, input int tl, input int ks,
                          input int stall_at, input int stall_len, input bit rand_stall);
    int g, og, ot, eks, ntaps, stall_left, tail, kr, kc;
    bit stalled_prev, finished;
    logic [SIZE*AW-1:0] exp_addr;

    eks = (ks == 0) ? 1 : ks;
    ntaps = eks * eks;
    g = 0; og = 0; ot = 0; tail = 0;
    stall_left = stall_len;
    stalled_prev = 1'b0;
    finished = 1'b0;
    r_cont = 0; r_done = 0; r_done_cyc = -1;
    for (int i = 0; i < 4; i++) begin r_first_cyc[i] = -1; r_last_cyc[i] = -1; end

    @(negedge clock);
    addr_gen_done = 1'b0;
    rd_stall      = 1'b0;
    tile_length   = 6'(tl);
    ksize         = 3'(ks);
    drive_group(0, ngroups);
    repeat (2) @(negedge clock);
    addr_gen_done = 1'b1;

    for (int budget = 0; budget < 2000 && !finished; budget++) begin
      @(negedge clock);
      if (stalled_prev) begin
        n_total++;
        if (rd_valid !== '0 || rd_first !== 1'b0 || rd_last !== 1'b0)
          $display("FAIL stall_bubble: valid=%b first=%b last=%b, required 0", rd_valid, rd_first, rd_last);
        else n_pass++;
      end
      if (rd_valid !== '0 || rd_first === 1'b1 || rd_last === 1'b1) begin
        if (og >= ngroups) begin
          n_total++;
          $display("FAIL extra_tap: valid=%b after %0d groups, required no tap", rd_valid, ngroups);
        end else begin
          kr = ot / eks;
          kc = ot % eks;
          for (int i = 0; i < SIZE; i++)
            exp_addr[i*AW +: AW] = AW'(int'(g_base[og][i]) + kr * tl + kc);
          n_total++;
          if (rd_addr !== exp_addr)
            $display("FAIL tap_addr g%0d t%0d: got %h, required %h", og, ot, rd_addr, exp_addr);
          else n_pass++;
          n_total++;
          if (rd_valid !== g_valid[og])
            $display("FAIL tap_valid g%0d t%0d: got %b, required %b", og, ot, rd_valid, g_valid[og]);
          else n_pass++;
          n_total++;
          if (rd_first !== (ot == 0) || rd_last !== (ot == ntaps - 1))
            $display("FAIL tap_flags g%0d t%0d: first=%b last=%b, required first=%b last=%b",
                     og, ot, rd_first, rd_last, ot == 0, ot == ntaps - 1);
          else n_pass++;
          if (ot == 0) r_first_cyc[og] = cyc;
          if (ot == ntaps - 1) r_last_cyc[og] = cyc;
          ot++;
          if (ot == ntaps) begin ot = 0; og++; end
        end
      end
      if (tile_continue === 1'b1) begin
        r_cont++;
        g++;
        if (g < ngroups) drive_group(g, ngroups);
      end
      if (tile_done === 1'b1) begin r_done++; r_done_cyc = cyc; end
      if (r_done > 0) begin
        tail++;
        if (tail == 3) finished = 1'b1;
      end
      if (rand_stall) rd_stall = ($urandom_range(0, 3) == 0);
      else if (og == 0 && ot == stall_at && stall_left > 0) begin
        rd_stall = 1'b1;
        stall_left--;
      end else rd_stall = 1'b0;
      stalled_prev = rd_stall;
    end
    rd_stall      = 1'b0;
    addr_gen_done = 1'b0;
    r_groups_seen = og;

    n_total++;
    if (!finished) $display("FAIL tile_timeout: tile_done count %0d, required 1 within budget", r_done);
    else n_pass++;
    n_total++;
    if (og != ngroups || ot != 0)
      $display("FAIL tap_count: %0d groups + %0d taps seen, required %0d groups", og, ot, ngroups);
    else n_pass++;
    n_total++;
    if (r_cont != ngroups - 1) $display("FAIL continue_count: got %0d, required %0d", r_cont, ngroups - 1);
    else n_pass++;
    n_total++;
    if (r_done != 1) $display("FAIL done_count: got %0d, required 1", r_done);
    else n_pass++;
    n_total++;
    if (r_done_cyc != r_last_cyc[ngroups-1] || r_done_cyc < 0)
      $display("FAIL done_timing: tile_done cycle %0d, required %0d (last tap out)", r_done_cyc, r_last_cyc[ngroups-1]);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL idle_after_tile: busy=%b, required 0", busy);
    else n_pass++;
  endtask

  task automatic fill_random(input int ngroups);
    for (int g = 0; g < ngroups; g++) begin
      for (int i = 0; i < SIZE; i++) g_base[g][i] = AW'($urandom_range(0, 1023));
      g_valid[g] = SIZE'($urandom_range(1, 255));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    addr_gen_done = 1'b0; ifmap_end = 1'b0; rd_stall = 1'b0;
    base_address = '0; base_addr_valid = '0; tile_length = '0; ksize = '0;
    repeat (3) @(negedge clock);
    outputs_zero("reset_state");
    rst = 1'b0;
    repeat (2) @(negedge clock);
    outputs_zero("idle_after_reset");
  endtask

  task automatic test_single_group();
    for (int i = 0; i < SIZE; i++) g_base[0][i] = AW'(i);
    g_valid[0] = '1;
    run_tile(1, 8, 3, -1, 0, 1'b0);
  endtask

  task automatic test_two_groups();
    fill_random(2);
    g_valid[0] = '1; g_valid[1] = '1;
    run_tile(2, $urandom_range(1, 63), 1, -1, 0, 1'b0);
    n_total++;
    if (r_first_cyc[1] - r_last_cyc[0] != 3)
      $display("FAIL group_gap: %0d cycles, required 3", r_first_cyc[1] - r_last_cyc[0]);
    else n_pass++;
  endtask

  task automatic test_partial();
    fill_random(1);
    g_valid[0] = 8'b0000_0111;
    run_tile(1, $urandom_range(1, 63), 2, -1, 0, 1'b0);
  endtask

  task automatic test_stall();
    fill_random(1);
    g_valid[0] = '1;
    run_tile(1, 8, 3, 4, 3, 1'b0);
    n_total++;
    if (r_last_cyc[0] - r_first_cyc[0] + 1 != 12)
      $display("FAIL stall_scan_len: %0d cycles, required 12", r_last_cyc[0] - r_first_cyc[0] + 1);
    else n_pass++;
  endtask

  task automatic test_wrap();
    fill_random(1);
    g_base[0][0] = AW'(1020);
    g_valid[0] = '1;
    run_tile(1, 32, 2, -1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_scan();
    bit seen, bad;
    fill_random(1);
    g_valid[0] = '1;
    @(negedge clock);
    tile_length = 6'd10; ksize = 3'd5;
    drive_group(0, 1);
    @(negedge clock);
    addr_gen_done = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      if (rd_valid !== '0) seen = 1'b1;
    end
    n_total++;
    if (!seen) $display("FAIL scan_start_timeout: rd_valid=%b, required nonzero", rd_valid);
    else n_pass++;
    @(negedge clock);
    #2 rst = 1'b1;
    #1 outputs_zero("async_reset");
    @(negedge clock);
    outputs_zero("reset_held");
    rst = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (busy !== 1'b0 || rd_valid !== '0) bad = 1'b1;
    end
    n_total++;
    if (bad) $display("FAIL level_no_restart: busy=%b valid=%b, required 0", busy, rd_valid);
    else n_pass++;
    addr_gen_done = 1'b0;
    fill_random(1);
    run_tile(1, $urandom_range(0, 63), 3, -1, 0, 1'b0);
  endtask

  task automatic test_random();
    int ng;
    for (int t = 0; t < 8; t++) begin
      ng = $urandom_range(1, 4);
      fill_random(ng);
      run_tile(ng, $urandom_range(0, 63), $urandom_range(0, 5), -1, 0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single_group();
    test_two_groups();
    test_partial();
    test_stall();
    test_wrap();
    test_reset_mid_scan();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifm_window_rd.md
Name: ifm_window_rd

Overview:
- Sits directly downstream of the ifmap base-address generator (ifm_addr_gen).
- Consumes each group of 8 convolution-window base addresses and expands every group into ksize*ksize per-tap ifmap buffer read addresses, one tap per cycle, for 8 lanes in parallel.
- Requests the next group from the generator over the tile_continue handshake.
- Pulses tile_done after the last tap of the last group.

Parameters:
SIZE, 8, number of parallel lanes (base addresses per group)
AW, 10, address width per lane (32x32 tile maximum)

Ports:
clock  in  1  system clock
rst  in  1  reset, asynchronous, active-high
base_address  in  SIZE*AW  lane i base at bits [i*AW +: AW], from generator
base_addr_valid  in  SIZE  per-lane valid, from generator
addr_gen_done  in  1  generator has a tile loaded; rising edge starts the block
ifmap_end  in  1  generator has issued its final group
tile_length  in  6  tile row length (ifmap row pitch)
ksize  in  3  kernel size, 1..5
rd_stall  in  1  downstream buffer busy; freeze tap scan
tile_continue  out  1  one-cycle request for the next base-address group
rd_addr  out  SIZE*AW  per-lane tap read address, same lane packing as base_address
rd_valid  out  SIZE  per-lane tap valid
rd_first  out  1  first tap (kr=0,kc=0) of a group
rd_last  out  1  last tap (kr=kc=ksize-1) of a group
tile_done  out  1  one-cycle pulse after the final tap of the tile
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0 (tile_continue, rd_addr, rd_valid, rd_first, rd_last, tile_done, busy). All counters and latches cleared. Reset mid-scan drops the tile; outputs clear immediately.
- States and transitions:
  - IDLE: on rising edge of addr_gen_done (registered compare), go to LOAD.
  - LOAD: 1 cycle. Lets the generator drive its first group.
  - CAPT: latch base_address, base_addr_valid and ifmap_end into end_l. On the first group only, also latch tile_length and ksize; ksize=0 is treated as 1. Clear kr, kc and row_off. Go to SCAN.
  - SCAN: one tap per unstalled cycle.
    - rd_stall=1: kr, kc and row_off hold.
    - Otherwise kc increments. At kc=ksize-1: kc=0, kr increments, row_off += tile_length.
    - After the tap with kr=kc=ksize-1: go to DONE if end_l=1, else go to REQ.
  - REQ: tile_continue=1 for exactly 1 cycle, then go to CAPT. The generator updates base_address on that edge.
  - DONE: tile_done=1 for 1 cycle, then go to IDLE.
- Output register (1-cycle latency from the SCAN cycle):
  - rd_addr[i] = (base_l[i] + row_off + kc) mod 2^AW.
  - rd_valid[i] = SCAN & ~rd_stall & valid_l[i].
  - rd_first and rd_last are qualified the same way as rd_valid.
  - rd_addr holds its last value when not valid.
- Arithmetic: row offset is accumulated incrementally, with no multiplier. Sums are AW-bit and wrap silently.
- Lanes whose valid bit is 0 (partial last group) still step, with rd_valid[i]=0.
- Throughput: ksize^2 + 2 cycles per group with no stall. Each rd_stall cycle adds one bubble.
- The generator drives ifmap_end high together with the last group, so end_l captured in CAPT is authoritative.
- A new addr_gen_done rising edge outside IDLE is ignored.
- tile_continue is never asserted outside REQ and never in the same cycle as CAPT.

Decomposition:
- Shared package (sdavinci_pkg):
  - SIZE and AW constants.
  - State encoding (one-hot localparams IDLE, LOAD, CAPT, SCAN, REQ, DONE).
  - Maximum ksize constant KMAX=5.
- One natural sub-module: ifm_tap_counter, holding kr, kc and row_off, with stall and last-tap detection. The lane adders and FSM stay in the top module.

Test Plan:
1. tile_length=8, ksize=3, bases 0..7 all valid, ifmap_end=1 at capture.
   - Lane0 rd_addr: 0,1,2,8,9,10,16,17,18.
   - Lane7 rd_addr: 7,8,9,15,16,17,23,24,25.
   - rd_first on tap 0, rd_last on tap 8.
   - tile_done 1 cycle after the last tap; no tile_continue pulse.
2. Two groups, ifmap_end=0 then 1, ksize=1.
   - Exactly one tile_continue pulse.
   - The second group's taps appear 3 cycles after the first group's tap.
   - tile_done after the second group.
3. Partial last group, base_addr_valid=8'b0000_0111, ksize=2.
   - Only rd_valid[2:0] toggle, for 4 taps.
   - Lanes 3..7 stay 0.
4. rd_stall held high for 3 cycles mid-scan (tap 4 of 9).
   - No rd_valid during the stall.
   - The tap sequence resumes at tap 4 with no skip or duplicate.
   - Total scan length is 12 cycles.
5. Wrap: base 1020, tile_length=32, ksize=2. Lane rd_addr: 1020, 1021, 28, 29 (mod 1024).
6. rst asserted during SCAN.
   - All outputs 0 asynchronously.
   - After release, the block waits for a fresh addr_gen_done rising edge; a level-high addr_gen_done does not restart it.
